fpu_sequencer: RTL
==================

# fpu_sequencer

Multi-cycle sequencer for the floating-point unit of the 5-stage pipeline. It accepts FP operations from the Decode stage and holds operands and opcode stable at the FPU for an op-dependent latency. It stalls Fetch/Decode and bubbles Execute while the operation runs, then performs a one-cycle register write-back of the result and accumulates sticky exception flags. Its stall and flush outputs are OR-ed with the hazard unit's StallF/StallD/FlushE.

## Interface
Parameters:
- LAT_ADD, 3, cycles from FpuStartE to a valid FPU result for add/sub
- LAT_MUL, 4, same for multiply
- LAT_DIV, 16, same for divide
- CNT_W, 5, latency counter width; must hold max(LAT_*)-1

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; all state and outputs cleared
- FpReqD  in  1  Decode holds an FP op (Extension decoded)
- FpOpD  in  4  FP opcode
- FpRdD  in  5  destination register
- FpAD, FpBD  in  32 each  operands from FP register file
- FlushD  in  1  Decode instruction squashed (taken branch/jump)
- FpuResult  in  32  FPU result
- FpuExc, FpuOvf, FpuUnf  in  1 each  FPU exception/overflow/underflow
- FlagClr  in  1  clear sticky flags
- FpuStartE  out  1  one-cycle start pulse to FPU
- FpuOpE  out  4  held opcode
- FpuAE, FpuBE  out  32 each  held operands
- FpStallF, FpStallD, FpFlushE  out  1 each  pipeline control
- FpBusy  out  1  state != IDLE
- FpRegWriteW  out  1  write-back strobe
- FpRdW  out  5  write-back register
- FpResultW  out  32  write-back data
- FpIllegal  out  1  one-cycle pulse, unsupported opcode
- FFlags  out  3  sticky {Exc, Ovf, Unf}

## Operation
- Opcodes (package): FP_ADD=4'h0, FP_SUB=4'h1, FP_MUL=4'h2, FP_DIV=4'h3; all others illegal.
- FSM states: IDLE, BUSY, WB.
- IDLE: accept when FpReqD & ~FlushD & legal opcode. On accept, register op, Rd, and operands; set cnt = LAT(op)-1; FpuStartE=1 next cycle; go to BUSY.
- Illegal opcode with FpReqD & ~FlushD: no accept; FpIllegal=1 next cycle; stay IDLE.
- BUSY: if cnt!=0, cnt--. If cnt==0, register FpuResult into FpResultW, OR FPU flags into FFlags unless FpuExc, and go to WB.
- WB: FpRegWriteW=1 unless the captured FpuExc=1 (write suppressed; FFlags[2] still set); go to IDLE.
- FpReqD is ignored in BUSY and WB. The stalled D instruction is re-evaluated in IDLE.
- FpStallF = FpStallD = FpFlushE = (state==BUSY | state==WB), combinational from state.
- FlagClr clears FFlags. If FlagClr and a flag set occur in the same cycle, the set wins.
- FpuAE/FpuBE/FpuOpE hold their values outside BUSY; reset value is 0.

## Timing
- Accept in cycle t. FpuStartE is high in t+1 only. BUSY spans t+1..t+LAT. Result is sampled at the end of t+LAT. WB is t+LAT+1. IDLE from t+LAT+2.
- Total occupancy is LAT+1 stall cycles. The next FP op can be accepted at t+LAT+2, earliest.
- Stalls cover WB, so the held D instruction reads the register file after the write.
- Reset mid-operation: immediate return to IDLE. All outputs, cnt, and FFlags go to 0. No write-back, no FpuStartE.
- Reset values: every output is 0.

## Structure
- Shared package fpu_pkg: opcode constants, state enum, and a function lat_of(op) returning the latency from the parameters.
- One sub-module, fpu_lat_counter: loadable down-counter with a zero flag. Everything else stays in fpu_sequencer.

## Test plan
- FP_ADD, A=32'h3F800000, B=32'h40000000, req at t:
  - FpuStartE at t+1.
  - Stalls high t+1..t+4.
  - FpRegWriteW with FpResultW=32'h40400000 at t+4 (LAT_ADD=3 → WB at t+LAT+1=t+4).
  - IDLE at t+5.
- FP_DIV: stalls held exactly 17 cycles. FpuAE/FpuBE stay stable throughout.
- FpReqD with FlushD=1: no accept, no stall, no start.
- FpOpD=4'h7: FpIllegal pulses 1 cycle, FpBusy stays 0.
- MUL with FpuOvf=1 at sample → FFlags=3'b010 and write occurs. FlagClr → 3'b000.
- FpuExc=1 at sample → no FpRegWriteW, FFlags[2]=1.
- Reset asserted at BUSY cnt=2 → all outputs 0 asynchronously. A subsequent ADD completes normally.
- Back-to-back FP ops: second accepted exactly one cycle after WB.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FP sequencer: opcodes, FSM states, latency lookup.
package fpu_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned FLAG_W = 3;

    localparam logic [OP_W-1:0] FP_ADD = 4'h0;
    localparam logic [OP_W-1:0] FP_SUB = 4'h1;
    localparam logic [OP_W-1:0] FP_MUL = 4'h2;
    localparam logic [OP_W-1:0] FP_DIV = 4'h3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WB   = 2'd2
    } fpState_t;

    // True for opcodes the FPU implements
    function automatic logic isLegalOp(input logic [OP_W-1:0] op);
        return (op == FP_ADD) || (op == FP_SUB) || (op == FP_MUL) || (op == FP_DIV);
    endfunction

    // FPU latency for an opcode; illegal opcodes return 0 and are never loaded
    function automatic int unsigned lat_of(input logic [OP_W-1:0] op,
                                           input int unsigned latAdd,
                                           input int unsigned latMul,
                                           input int unsigned latDiv);
        case (op)
            FP_ADD, FP_SUB: return latAdd;
            FP_MUL:         return latMul;
            FP_DIV:         return latDiv;
            default:        return 0;
        endcase
    endfunction

endpackage

// File: rtl/fpu_lat_counter.sv
// Loadable down-counter that stops at zero and flags it.
module fpu_lat_counter #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] loadVal,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             isZero
);

    // Load takes priority over decrement; decrement saturates at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= loadVal;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign isZero = (cnt == '0);

endmodule

// File: rtl/fpu_sequencer.sv
// Multi-cycle FP operation sequencer: holds FPU operands, stalls the front of
// the pipeline for the op latency, then writes the result back for one cycle.
module fpu_sequencer
    import fpu_pkg::*;
#(
    parameter int unsigned LAT_ADD = 3,
    parameter int unsigned LAT_MUL = 4,
    parameter int unsigned LAT_DIV = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              FpReqD,
    input  logic [OP_W-1:0]   FpOpD,
    input  logic [REG_W-1:0]  FpRdD,
    input  logic [DATA_W-1:0] FpAD,
    input  logic [DATA_W-1:0] FpBD,
    input  logic              FlushD,
    input  logic [DATA_W-1:0] FpuResult,
    input  logic              FpuExc,
    input  logic              FpuOvf,
    input  logic              FpuUnf,
    input  logic              FlagClr,
    output logic              FpuStartE,
    output logic [OP_W-1:0]   FpuOpE,
    output logic [DATA_W-1:0] FpuAE,
    output logic [DATA_W-1:0] FpuBE,
    output logic              FpStallF,
    output logic              FpStallD,
    output logic              FpFlushE,
    output logic              FpBusy,
    output logic              FpRegWriteW,
    output logic [REG_W-1:0]  FpRdW,
    output logic [DATA_W-1:0] FpResultW,
    output logic              FpIllegal,
    output logic [FLAG_W-1:0] FFlags
);

    fpState_t           state;
    logic [REG_W-1:0]   rdHeld;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cntLoadVal;
    logic               cntZero;
    logic               reqValid;
    logic               opLegal;
    logic               accept;
    logic               sampleNow;
    logic [FLAG_W-1:0]  flagSet;

    // Decode-side request qualification
    assign reqValid   = FpReqD && !FlushD;
    assign opLegal    = isLegalOp(FpOpD);
    assign accept     = (state == IDLE) && reqValid && opLegal;
    assign cntLoadVal = CNT_W'(lat_of(FpOpD, LAT_ADD, LAT_MUL, LAT_DIV) - 1);
    assign sampleNow  = (state == BUSY) && cntZero;
    assign flagSet    = sampleNow ? {FpuExc, FpuOvf, FpuUnf} : '0;

    // Remaining FPU cycles; loaded with LAT-1 so zero marks the sample cycle
    fpu_lat_counter #(
        .CNT_W (CNT_W)
    ) u_latCounter (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .loadVal (cntLoadVal),
        .dec     (state == BUSY),
        .cnt     (cnt),
        .isZero  (cntZero)
    );

    // Sequencer FSM with registered FPU-side and write-back outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rdHeld      <= '0;
            FpuStartE   <= 1'b0;
            FpuOpE      <= '0;
            FpuAE       <= '0;
            FpuBE       <= '0;
            FpRegWriteW <= 1'b0;
            FpRdW       <= '0;
            FpResultW   <= '0;
            FpIllegal   <= 1'b0;
        end else begin
            FpuStartE   <= 1'b0;
            FpRegWriteW <= 1'b0;
            FpIllegal   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        FpuOpE    <= FpOpD;
                        FpuAE     <= FpAD;
                        FpuBE     <= FpBD;
                        rdHeld    <= FpRdD;
                        FpuStartE <= 1'b1;
                        state     <= BUSY;
                    end else if (reqValid) begin
                        FpIllegal <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cntZero) begin
                        // A faulting result is never written to the register file
                        if (!FpuExc) begin
                            FpResultW <= FpuResult;
                        end
                        FpRdW       <= rdHeld;
                        FpRegWriteW <= !FpuExc;
                        state       <= WB;
                    end
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky flags; a set in the same cycle as a clear is kept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            FFlags <= '0;
        end else begin
            FFlags <= (FlagClr ? '0 : FFlags) | flagSet;
        end
    end

    // Pipeline control straight from the state register
    assign FpBusy   = (state != IDLE);
    assign FpStallF = (state == BUSY) || (state == WB);
    assign FpStallD = FpStallF;
    assign FpFlushE = FpStallF;

endmodule
